raw_data_out_arb: RTL and testbench

RAW_DATA_OUT_ARB -- requirements
Module: raw_data_out_arb

---
 rtl/raw_data_out_arb.sv | 127 ++++++++++++
 tb/tb_raw_data_out_arb.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/raw_data_out_arb.sv
// raw_data_out_arb: round-robin arbiter that lets four requesters stream
// packets into one shared output FIFO. A grant is held for a whole packet
// (through FIFO-full stalls and valid gaps) and released on the last word.
// Optional watchdog: define RAW_DATA_OUT_ARB_WDOG_EN to revoke a grant whose
// owner stops presenting data for WDOG_CYCLES cycles.
module raw_data_out_arb #(
  parameter int DATA_W      = 32,
  parameter int WDOG_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  arb_clr,
  input  logic [3:0]            req_valid,
  input  logic [3:0]            req_last,
  input  logic [4*DATA_W-1:0]   req_data,
  output logic [3:0]            req_ready,
  input  logic                  raw_data_out_fifo_full,
  output logic                  raw_data_out_fifo_push,
  output logic [DATA_W-1:0]     raw_data_out_fifo_data,
  output logic [1:0]            grant_id,
  output logic                  grant_active,
  output logic                  wdog_abort
);

  typedef enum logic [1:0] {
    IDLE = 2'b01,
    XFER = 2'b10
  } state_t;

  if (WDOG_CYCLES < 2 || WDOG_CYCLES > 255) begin : g_bad_param
    $error("raw_data_out_arb: WDOG_CYCLES must be in 2..255");
  end

  state_t                   state, state_nxt;
  logic [1:0]               rr_ptr, rr_nxt, grant_nxt, pick;
  logic [3:0][DATA_W-1:0]   req_word;
  logic                     in_xfer, xfer, stall, abort;

  for (genvar n = 0; n < 4; n++) begin : g_slice
    assign req_word[n] = req_data[n*DATA_W +: DATA_W];
  end

  // Data path is a plain mux on the current grant; only meaningful with push.
  assign raw_data_out_fifo_data = req_word[grant_id];

  assign in_xfer      = (state == XFER);
  assign grant_active = in_xfer;
  // A word moves only when the owner has data and the FIFO has room; a
  // clear in the same cycle suppresses it so no word is half-accepted.
  assign xfer  = in_xfer & req_valid[grant_id] & ~raw_data_out_fifo_full & ~arb_clr;
  assign stall = in_xfer & ~req_valid[grant_id];

  assign raw_data_out_fifo_push = xfer;
  assign req_ready              = xfer ? (4'b0001 << grant_id) : 4'b0000;

  // Round-robin pick: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    pick = rr_ptr;
    for (int i = 3; i >= 0; i--) begin
      if (req_valid[rr_ptr + 2'(i)]) pick = rr_ptr + 2'(i);
    end
  end

`ifdef RAW_DATA_OUT_ARB_WDOG_EN
  localparam logic [7:0] WDOG_LAST = 8'(WDOG_CYCLES - 1);
  logic [7:0] wdog_cnt;

  // The abort fires on the stall cycle that would bring the count to the limit.
  assign abort = stall & ~arb_clr & (wdog_cnt == WDOG_LAST);

  // Count consecutive owner-idle cycles in XFER; any transfer or exit restarts it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdog_cnt   <= 8'd0;
      wdog_abort <= 1'b0;
    end else begin
      wdog_abort <= abort;
      if (!in_xfer || arb_clr || xfer || abort) wdog_cnt <= 8'd0;
      else if (stall)                            wdog_cnt <= wdog_cnt + 8'd1;
    end
  end
`else
  assign abort      = 1'b0;
  assign wdog_abort = 1'b0;
`endif

  // Next-state logic: clear wins, otherwise arbitrate in IDLE and release
  // the grant on the last word or a watchdog abort.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant_id;
    rr_nxt    = rr_ptr;
    if (arb_clr) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            state_nxt = XFER;
            grant_nxt = pick;
          end
        end
        XFER: begin
          if ((xfer && req_last[grant_id]) || abort) begin
            state_nxt = IDLE;
            rr_nxt    = grant_id + 2'd1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State, grant and pointer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      grant_id <= 2'd0;
      rr_ptr   <= 2'd0;
    end else begin
      state    <= state_nxt;
      grant_id <= grant_nxt;
      rr_ptr   <= rr_nxt;
    end
  end

endmodule

// File: tb/tb_raw_data_out_arb.sv
// Bench for raw_data_out_arb: directed scenarios with literal expectations
// plus a randomized run, all compared every cycle against a packet-level
// model of the arbitration rules.
module tb_raw_data_out_arb;
  localparam int DW = 32;
  localparam int WD = 16;
`ifdef RAW_DATA_OUT_ARB_WDOG_EN
  localparam bit WDOG = 1'b1;
`else
  localparam bit WDOG = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset, arb_clr, full, push, grant_active, wdog_abort;
  logic [3:0]      req_valid, req_last, req_ready;
  logic [4*DW-1:0] req_data;
  logic [DW-1:0]   fdata;
  logic [1:0]      grant_id;

  always #5 clk = ~clk;

  raw_data_out_arb #(.DATA_W(DW), .WDOG_CYCLES(WD)) dut (
    .clk(clk), .reset(reset), .arb_clr(arb_clr),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready),
    .raw_data_out_fifo_full(full), .raw_data_out_fifo_push(push),
    .raw_data_out_fifo_data(fdata),
    .grant_id(grant_id), .grant_active(grant_active), .wdog_abort(wdog_abort)
  );

  int total = 0, bad = 0;
  int npush;
  int gq[$];

  // model: who owns the FIFO, the round-robin start point, idle count
  bit m_busy, m_abort;
  int m_gid, m_ptr, m_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_abort = 0; m_gid = 0; m_ptr = 0; m_cnt = 0;
  endtask

  task automatic compare_now();
    bit ep;
    ep = m_busy && req_valid[m_gid] && !full && !arb_clr && !reset;
    chk("push", push, ep);
    chk("ready", req_ready, ep ? (64'd1 << m_gid) : 64'd0);
    chk("grant_id", grant_id, m_gid);
    chk("grant_active", grant_active, m_busy);
    chk("wdog_abort", wdog_abort, m_abort);
    if (ep) chk("data", fdata, req_data[m_gid*DW +: DW]);
    if (push) begin
      npush++;
      gq.push_back(int'(grant_id));
    end
  endtask

  task automatic model_step();
    bit sv, pm, ab;
    sv = req_valid[m_gid];
    pm = m_busy && sv && !full && !arb_clr;
    ab = WDOG && m_busy && !arb_clr && !sv && (m_cnt + 1 >= WD);
    m_abort = ab;
    if (arb_clr) begin
      m_busy = 0; m_cnt = 0;
    end else if (!m_busy) begin
      if (req_valid != 4'd0) begin
        for (int k = 0; k < 4; k++) begin
          if (req_valid[(m_ptr + k) % 4]) begin
            m_gid = (m_ptr + k) % 4;
            break;
          end
        end
        m_busy = 1; m_cnt = 0;
      end
    end else if ((pm && req_last[m_gid]) || ab) begin
      m_busy = 0; m_ptr = (m_gid + 1) % 4; m_cnt = 0;
    end else if (pm) begin
      m_cnt = 0;
    end else if (!sv) begin
      m_cnt++;
    end
  endtask

  task automatic cyc(input logic [3:0] v, input logic [3:0] l, input logic f, input logic c);
    @(negedge clk);
    req_valid = v; req_last = l; full = f; arb_clr = c;
    for (int k = 0; k < 4; k++) req_data[k*DW +: DW] = $urandom;
    #1 compare_now();
    @(posedge clk);
    model_step();
  endtask

  // Reset asserted mid-cycle with the current inputs still applied.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_push", push, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_active", grant_active, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_abort", wdog_abort, 0);
    model_reset();
    req_valid = 0; req_last = 0; full = 0; arb_clr = 0;
    #1 reset = 1'b0;
    @(posedge clk);
    model_step();
  endtask

  initial begin
    int exp_order[5] = '{0, 1, 2, 3, 0};
    reset = 1'b1; arb_clr = 0; req_valid = 0; req_last = 0; full = 0; req_data = '0;
    npush = 0;
    model_reset();
    #2;
    chk("init_gid", grant_id, 0);
    chk("init_active", grant_active, 0);
    chk("init_push", push, 0);
    #2 reset = 1'b0;

    // round-robin pointer moves past a finished requester
    do_reset();
    cyc(4'b0101, 4'b0000, 0, 0);
    #1 chk("s30_gid0", grant_id, 0);
    chk("s30_act", grant_active, 1);
    cyc(4'b0101, 4'b0001, 0, 0);
    #1 chk("s30_idle", grant_active, 0);
    cyc(4'b0101, 4'b0000, 0, 0);
    #1 chk("s30_gid2", grant_id, 2);

    // FIFO-full stall inside a 3-word packet
    do_reset();
    npush = 0;
    cyc(4'b0010, 4'b0000, 0, 0);
    cyc(4'b0010, 4'b0000, 0, 0);
    repeat (5) cyc(4'b0010, 4'b0000, 1, 0);
    cyc(4'b0010, 4'b0000, 0, 0);
    cyc(4'b0010, 4'b0010, 0, 0);
    #1 chk("s31_pushes", npush, 3);
    chk("s31_gid", grant_id, 1);
    chk("s31_idle", grant_active, 0);

    // all requesting, single-word packets
    do_reset();
    npush = 0; gq.delete();
    repeat (10) cyc(4'b1111, 4'b1111, 0, 0);
    chk("s32_pushes", npush, 5);
    for (int i = 0; i < 5 && i < gq.size(); i++) chk("s32_order", gq[i], exp_order[i]);

    // arb_clr during word 2 keeps the pointer
    do_reset();
    cyc(4'b0010, 4'b0010, 0, 0);
    cyc(4'b0010, 4'b0010, 0, 0);
    cyc(4'b0100, 4'b0000, 0, 0);
    cyc(4'b0100, 4'b0000, 0, 0);
    cyc(4'b0100, 4'b0000, 0, 1);
    #1 chk("s34c_idle", grant_active, 0);
    cyc(4'b1111, 4'b0000, 0, 0);
    #1 chk("s34c_gid", grant_id, 2);

    // reset during word 2 zeroes the pointer
    do_reset();
    cyc(4'b0010, 4'b0010, 0, 0);
    cyc(4'b0010, 4'b0010, 0, 0);
    cyc(4'b0100, 4'b0000, 0, 0);
    cyc(4'b0100, 4'b0000, 0, 0);
    do_reset();
    cyc(4'b1111, 4'b0000, 0, 0);
    #1 chk("s34r_gid", grant_id, 0);

    // owner goes silent mid-packet
    do_reset();
    cyc(4'b1000, 4'b0000, 0, 0);
    cyc(4'b1000, 4'b0000, 0, 0);
    repeat (15) cyc(4'b0000, 4'b0000, 0, 0);
    #1 chk("s33_noabort15", wdog_abort, 0);
    chk("s33_held15", grant_active, 1);
    cyc(4'b0000, 4'b0000, 0, 0);
    #1 chk("s33_abort", wdog_abort, WDOG);
    chk("s33_active", grant_active, !WDOG);
    cyc(4'b1111, 4'b0000, 0, 0);
    #1 chk("s33_gid", grant_id, WDOG ? 0 : 3);
    chk("s33_pulse", wdog_abort, 0);

    // randomized traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] v, l;
      v = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) v = 4'b0000;
      l = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        cyc(v, l, $urandom_range(0, 3) == 0, $urandom_range(0, 40) == 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
